// File: rtl/hart_issue_sched_if.sv
// Fetch-slot issue bundle between hart state unit, scheduler and IF.
// Ports: acti/prim hart masks, IF stall in; issue hid/valid/prim out.
interface hart_issue_sched_if #(
  parameter int HART_NUM  = 4,
  parameter int HART_ID_W = 2
);
  logic [HART_NUM-1:0]  acti_hstate;
  logic [HART_NUM-1:0]  prim_hstate;
  logic                 if_stall;
  logic [HART_ID_W-1:0] issue_hid;
  logic                 issue_valid;
  logic                 issue_prim;

  modport master (
    input  acti_hstate,
    input  prim_hstate,
    input  if_stall,
    output issue_hid,
    output issue_valid,
    output issue_prim
  );

  modport slave (
    output acti_hstate,
    output prim_hstate,
    output if_stall,
    input  issue_hid,
    input  issue_valid,
    input  issue_prim
  );
endinterface

// File: rtl/hart_issue_sched.sv
// Fetch-slot scheduler: primary hart gets PRIM_WEIGHT slots, then one RR
// secondary slot. Ports: clk, rst (async high), bus (master modport:
// acti/prim masks, if_stall in; registered issue_hid/valid/prim out).
// Optional starvation aging: define HART_SCHED_AGE_EN.
module hart_issue_sched #(
  parameter int HART_NUM    = 4,
  parameter int HART_ID_W   = 2,
  parameter int PRIM_WEIGHT = 3,
  parameter int AGE_MAX     = 8
) (
  input  logic clk,
  input  logic rst,
  hart_issue_sched_if.master bus
);

  typedef enum logic [1:0] {IDLE, PRIM, SEC} state_t;
  typedef enum logic [1:0] {S_NONE, S_PRIM, S_RR, S_AGE} sel_t;

  localparam logic [2:0] PW = 3'(PRIM_WEIGHT);

  state_t               state, nxt_state;
  sel_t                 sel;
  logic [2:0]           pcnt, nxt_pcnt;
  logic [HART_ID_W-1:0] rr_ptr, nxt_rr;
  logic [HART_ID_W-1:0] hid_q, nxt_hid;
  logic                 valid_q, nxt_valid;
  logic                 prim_q, nxt_prim;

  logic [HART_NUM-1:0]  prim_oh, sec;
  logic                 pact;
  logic [HART_ID_W-1:0] prim_id;
  logic                 rr_hit;
  logic [HART_ID_W-1:0] rr_id, rr_idx;
  logic                 age_hit;
  logic [HART_ID_W-1:0] age_id;

  // Lowest set bit of the primary mask is the primary hart.
  assign prim_oh = bus.prim_hstate & (~bus.prim_hstate + HART_NUM'(1));
  assign sec     = bus.acti_hstate & ~bus.prim_hstate;
  assign pact    = |(bus.acti_hstate & prim_oh);

  always_comb begin
    prim_id = '0;
    for (int i = 0; i < HART_NUM; i++)
      if (prim_oh[i]) prim_id = HART_ID_W'(i);
  end

  always_comb begin
    rr_hit = 1'b0;
    rr_id  = '0;
    rr_idx = '0;
    for (int i = 0; i < HART_NUM; i++) begin
      rr_idx = rr_ptr + HART_ID_W'(i);
      if (!rr_hit && sec[rr_idx]) begin
        rr_hit = 1'b1;
        rr_id  = rr_idx;
      end
    end
  end

`ifdef HART_SCHED_AGE_EN
  logic [3:0] age [HART_NUM];

  always_comb begin
    age_hit = 1'b0;
    age_id  = '0;
    for (int i = HART_NUM - 1; i >= 0; i--)
      if (sec[i] && age[i] == 4'(AGE_MAX)) begin
        age_hit = 1'b1;
        age_id  = HART_ID_W'(i);
      end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < HART_NUM; i++) age[i] <= '0;
    end else begin
      for (int i = 0; i < HART_NUM; i++) begin
        if (!bus.acti_hstate[i])
          age[i] <= '0;
        else if (!bus.if_stall) begin
          if (nxt_valid && nxt_hid == HART_ID_W'(i))
            age[i] <= '0;
          else if (sec[i] && age[i] != 4'(AGE_MAX))
            age[i] <= age[i] + 4'd1;
        end
      end
    end
  end
`else
  assign age_hit = 1'b0;
  assign age_id  = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pcnt    <= '0;
      rr_ptr  <= '0;
      hid_q   <= '0;
      valid_q <= 1'b0;
      prim_q  <= 1'b0;
    end else if (bus.if_stall) begin
      // Drop a held pick whose hart went inactive during the stall.
      valid_q <= valid_q & bus.acti_hstate[hid_q];
    end else begin
      state   <= nxt_state;
      pcnt    <= nxt_pcnt;
      rr_ptr  <= nxt_rr;
      hid_q   <= nxt_hid;
      valid_q <= nxt_valid;
      prim_q  <= nxt_prim;
    end
  end

  always_comb begin
    nxt_state = state;
    sel       = S_NONE;
    unique case (state)
      IDLE: begin
        if (pact) begin
          nxt_state = PRIM;
          sel       = S_PRIM;
        end else if (rr_hit) begin
          nxt_state = SEC;
          sel       = S_RR;
        end
      end
      PRIM: begin
        if (!pact) begin
          nxt_state = rr_hit ? SEC : IDLE;
          sel       = rr_hit ? S_RR : S_NONE;
        end else if (age_hit) begin
          nxt_state = SEC;
          sel       = S_AGE;
        end else if (pcnt == PW && rr_hit) begin
          nxt_state = SEC;
          sel       = S_RR;
        end else begin
          sel = S_PRIM;
        end
      end
      SEC: begin
        if (pact) begin
          nxt_state = PRIM;
          sel       = S_PRIM;
        end else if (rr_hit) begin
          sel = S_RR;
        end else begin
          nxt_state = IDLE;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_comb begin
    nxt_valid = (sel != S_NONE);
    nxt_hid   = '0;
    nxt_prim  = 1'b0;
    nxt_pcnt  = '0;
    nxt_rr    = rr_ptr;
    unique case (sel)
      S_PRIM: begin
        nxt_hid  = prim_id;
        nxt_prim = 1'b1;
        // A new primary restarts its run at one slot.
        if (state == PRIM && hid_q == prim_id)
          nxt_pcnt = (pcnt == PW) ? PW : pcnt + 3'd1;
        else
          nxt_pcnt = 3'd1;
      end
      S_RR: begin
        nxt_hid = rr_id;
        nxt_rr  = rr_id + HART_ID_W'(1);
      end
      S_AGE: begin
        nxt_hid = age_id;
        nxt_rr  = age_id + HART_ID_W'(1);
      end
      default: ;
    endcase
  end

  assign bus.issue_hid   = hid_q;
  assign bus.issue_valid = valid_q;
  assign bus.issue_prim  = prim_q;

endmodule

// File: tb/tb_hart_issue_sched.sv
// Directed bench for hart_issue_sched with an expected-issue queue.
// Second instance (weight 7, age max 4) covers the aging option.
module tb_hart_issue_sched;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hart_issue_sched_if #(.HART_NUM(4), .HART_ID_W(2)) bus ();
  hart_issue_sched_if #(.HART_NUM(4), .HART_ID_W(2)) bus2 ();

  assign bus2.acti_hstate = bus.acti_hstate;
  assign bus2.prim_hstate = bus.prim_hstate;
  assign bus2.if_stall    = bus.if_stall;

  hart_issue_sched #(
    .HART_NUM(4), .HART_ID_W(2), .PRIM_WEIGHT(3), .AGE_MAX(15)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  hart_issue_sched #(
    .HART_NUM(4), .HART_ID_W(2), .PRIM_WEIGHT(7), .AGE_MAX(4)
  ) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  typedef struct packed {
    logic       which;
    logic       v;
    logic [1:0] hid;
    logic       p;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic compare(input string tag, input exp_t e);
    logic       ov, op;
    logic [1:0] oh;
    ov = e.which ? bus2.issue_valid : bus.issue_valid;
    oh = e.which ? bus2.issue_hid   : bus.issue_hid;
    op = e.which ? bus2.issue_prim  : bus.issue_prim;
    n_chk++;
    assert (ov === e.v) else begin
      n_fail++;
      $error("FAIL %s valid obs=%0b exp=%0b", tag, ov, e.v);
    end
    n_chk++;
    assert (op === e.p) else begin
      n_fail++;
      $error("FAIL %s prim obs=%0b exp=%0b", tag, op, e.p);
    end
    if (e.v) begin
      n_chk++;
      assert (oh === e.hid) else begin
        n_fail++;
        $error("FAIL %s hid obs=%0d exp=%0d", tag, oh, e.hid);
      end
    end
  endtask

  task automatic step(input string tag, input logic which,
                      input logic [3:0] a, input logic [3:0] pr,
                      input logic st, input logic ev,
                      input logic [1:0] eh, input logic ep);
    exp_t e;
    bus.acti_hstate = a;
    bus.prim_hstate = pr;
    bus.if_stall    = st;
    q.push_back('{which: which, v: ev, hid: eh, p: ep});
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL %s queue obs=empty exp=entry", tag);
    end else begin
      e = q.pop_front();
      compare(tag, e);
    end
  endtask

  // Async reset pulse mid-cycle, checked before any clock edge.
  task automatic do_reset(input string tag);
    #3;
    bus.acti_hstate = '0;
    bus.prim_hstate = '0;
    bus.if_stall    = 1'b0;
    rst = 1'b1;
    #1;
    compare(tag, '{which: 1'b0, v: 1'b0, hid: 2'd0, p: 1'b0});
    n_chk++;
    assert (bus.issue_hid === 2'd0) else begin
      n_fail++;
      $error("FAIL %s rst_hid obs=%0d exp=0", tag, bus.issue_hid);
    end
    compare(tag, '{which: 1'b1, v: 1'b0, hid: 2'd0, p: 1'b0});
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bus.acti_hstate = '0;
    bus.prim_hstate = '0;
    bus.if_stall    = 1'b0;
    #2;
    @(posedge clk);
    #1;
    do_reset("rst0");

    for (int k = 0; k < 2; k++) begin
      step("w3_p", 0, 4'b0101, 4'b0001, 0, 1, 2'd0, 1);
      step("w3_p", 0, 4'b0101, 4'b0001, 0, 1, 2'd0, 1);
      step("w3_p", 0, 4'b0101, 4'b0001, 0, 1, 2'd0, 1);
      step("w3_s", 0, 4'b0101, 4'b0001, 0, 1, 2'd2, 0);
    end

    do_reset("rst_rr");
    for (int k = 0; k < 4; k++) begin
      logic [1:0] s;
      s = (k == 3) ? 2'd1 : 2'(k + 1);
      step("rr_p", 0, 4'b1111, 4'b0001, 0, 1, 2'd0, 1);
      step("rr_p", 0, 4'b1111, 4'b0001, 0, 1, 2'd0, 1);
      step("rr_p", 0, 4'b1111, 4'b0001, 0, 1, 2'd0, 1);
      step("rr_s", 0, 4'b1111, 4'b0001, 0, 1, s, 0);
    end

    do_reset("rst_mv");
    step("mv_p0", 0, 4'b0011, 4'b0001, 0, 1, 2'd0, 1);
    step("mv_p0", 0, 4'b0011, 4'b0001, 0, 1, 2'd0, 1);
    step("mv_p0", 0, 4'b0011, 4'b0001, 0, 1, 2'd0, 1);
    step("mv_s1", 0, 4'b0011, 4'b0001, 0, 1, 2'd1, 0);
    for (int k = 0; k < 5; k++)
      step("mv_p1", 0, 4'b0010, 4'b0010, 0, 1, 2'd1, 1);
    step("mv_none", 0, 4'b0000, 4'b0010, 0, 0, 2'd0, 0);
    step("mv_idle", 0, 4'b0000, 4'b0000, 0, 0, 2'd0, 0);

    do_reset("rst_chg");
    step("chg_p0", 0, 4'b0011, 4'b0001, 0, 1, 2'd0, 1);
    step("chg_p0", 0, 4'b0011, 4'b0001, 0, 1, 2'd0, 1);
    step("chg_p1a", 0, 4'b0011, 4'b0010, 0, 1, 2'd1, 1);
    step("chg_p1b", 0, 4'b0011, 4'b0010, 0, 1, 2'd1, 1);
    step("chg_p1c", 0, 4'b0011, 4'b0010, 0, 1, 2'd1, 1);
    step("chg_s0", 0, 4'b0011, 4'b0010, 0, 1, 2'd0, 0);

    do_reset("rst_noh");
    step("noh_p", 0, 4'b1111, 4'b0110, 0, 1, 2'd1, 1);
    step("noh_p", 0, 4'b1111, 4'b0110, 0, 1, 2'd1, 1);
    step("noh_p", 0, 4'b1111, 4'b0110, 0, 1, 2'd1, 1);
    step("noh_s0", 0, 4'b1111, 4'b0110, 0, 1, 2'd0, 0);
    step("noh_p", 0, 4'b1111, 4'b0110, 0, 1, 2'd1, 1);
    step("noh_p", 0, 4'b1111, 4'b0110, 0, 1, 2'd1, 1);
    step("noh_p", 0, 4'b1111, 4'b0110, 0, 1, 2'd1, 1);
    step("noh_s3", 0, 4'b1111, 4'b0110, 0, 1, 2'd3, 0);

    do_reset("rst_stl");
    step("stl_p", 0, 4'b0101, 4'b0001, 0, 1, 2'd0, 1);
    step("stl_p", 0, 4'b0101, 4'b0001, 0, 1, 2'd0, 1);
    step("stl_hold", 0, 4'b0101, 4'b0001, 1, 1, 2'd0, 1);
    step("stl_kill", 0, 4'b0100, 4'b0001, 1, 0, 2'd0, 1);
    step("stl_kill", 0, 4'b0100, 4'b0001, 1, 0, 2'd0, 1);
    step("stl_kill", 0, 4'b0100, 4'b0001, 1, 0, 2'd0, 1);
    step("stl_rel", 0, 4'b0100, 4'b0001, 0, 1, 2'd2, 0);
    step("stl_p1", 0, 4'b0101, 4'b0001, 0, 1, 2'd0, 1);
    step("stl_p2", 0, 4'b0101, 4'b0001, 0, 1, 2'd0, 1);
    step("stl_p3", 0, 4'b0101, 4'b0001, 0, 1, 2'd0, 1);
    step("stl_s", 0, 4'b0101, 4'b0001, 0, 1, 2'd2, 0);

    do_reset("rst_age");
`ifdef HART_SCHED_AGE_EN
    for (int k = 0; k < 4; k++)
`else
    for (int k = 0; k < 7; k++)
`endif
      step("age_p", 1, 4'b0011, 4'b0001, 0, 1, 2'd0, 1);
    step("age_s", 1, 4'b0011, 4'b0001, 0, 1, 2'd1, 0);
    step("age_back", 1, 4'b0011, 4'b0001, 0, 1, 2'd0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
